pipelined_rca: RTL and testbench

PIPELINED_RCA -- requirements
Module: pipelined_rca

---
 rtl/pipelined_rca.sv | 120 ++++++++++++
 tb/tb_pipelined_rca.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca.sv
// Ripple-carry adder/subtractor split into STAGES registered chunks; valid/ready on both sides.
// Latency STAGES cycles, one result per cycle; empty stages always fill, so bubbles collapse.
module pipelined_rca #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         Sub,
  input  logic         Cin,
  input  logic [N-1:0] operA,
  input  logic [N-1:0] operB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] resultOUT,
  output logic         Cout,
  output logic         Ovf
);

  localparam int W = N / STAGES;

  if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_param_check
    $error("pipelined_rca: N must be a multiple of STAGES and 1 <= STAGES <= N");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] pred_v;
  logic [STAGES:0]   adv;
  logic [N-1:0]      a_q [STAGES];
  logic [N-1:0]      b_q [STAGES];
  logic [N-1:0]      r_q [STAGES];
  logic [N-1:0]      a_d [STAGES];
  logic [N-1:0]      b_d [STAGES];
  logic [N-1:0]      r_d [STAGES];
  logic              ovf_q;
  logic              ovf_d;
  logic              carry;
  logic              carry_msb;

  // Stage k sees the operands/partial result registered by stage k-1; stage 0 sees the ports.
  // Subtraction is folded in at the entry: invert B and force the carry-in to 1.
  always_comb begin
    a_d[0]      = operA;
    b_d[0]      = Sub ? ~operB : operB;
    r_d[0]      = '0;
    carry_in[0] = Sub | Cin;
    pred_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]      = a_q[k-1];
      b_d[k]      = b_q[k-1];
      r_d[k]      = r_q[k-1];
      carry_in[k] = c_q[k-1];
      pred_v[k]   = v_q[k-1];
    end
    c_d       = '0;
    carry     = 1'b0;
    carry_msb = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      carry = carry_in[k];
      for (int i = 0; i < W; i++) begin
        carry_msb        = carry;
        r_d[k][k*W + i]  = a_d[k][k*W + i] ^ b_d[k][k*W + i] ^ carry;
        carry            = (a_d[k][k*W + i] & b_d[k][k*W + i]) |
                           (carry & (a_d[k][k*W + i] ^ b_d[k][k*W + i]));
      end
      c_d[k] = carry;
    end
    // After the last chunk, carry_msb is the carry into bit N-1 and carry the carry out of it.
    ovf_d = carry_msb ^ carry;
  end

  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= pred_v[k];
          // Data only moves with a valid token so idle inputs never disturb held state.
          if (pred_v[k]) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            r_q[k] <= r_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
      if (adv[STAGES-1] && pred_v[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign resultOUT = r_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca: driver pushes expected results from an arithmetic
// model, a monitor pops and compares on every output transfer.
module tb_pipelined_rca;
  localparam int N      = 32;
  localparam int STAGES = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         Sub;
  logic         Cin;
  logic [N-1:0] operA;
  logic [N-1:0] operB;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] resultOUT;
  logic         Cout;
  logic         Ovf;

  typedef struct {
    logic [N-1:0] res;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int n_drop = 0;
  int or_mode = 0;
  int phase_start = 0;
  bit lat_chk = 0;
  bit full_seen = 0;

  pipelined_rca #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sub(Sub), .Cin(Cin), .operA(operA), .operB(operB),
    .out_valid(out_valid), .out_ready(out_ready),
    .resultOUT(resultOUT), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Signed/unsigned integer arithmetic on 64-bit values, independent of any carry chain.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ua, ub, sa, sbv, s, sd, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lim = longint'(1) <<< (N - 1);
    if (sub) begin
      s      = ua - ub;
      e.cout = (ua >= ub);
      sd     = sa - sbv;
    end else begin
      s      = ua + ub + longint'(cin);
      e.cout = (s >= 2 * lim);
      sd     = sa + sbv + longint'(cin);
    end
    e.res = s[N-1:0];
    e.ovf = (sd >= lim) || (sd < -lim);
    e.cyc = 0;
    return e;
  endfunction

  // Output consumer: 0 always ready, 1 random, 2 scripted stall window, 3 never ready.
  always @(negedge clk) begin
    case (or_mode)
      0:       out_ready <= 1'b1;
      1:       out_ready <= ($urandom_range(0, 3) != 0);
      2:       out_ready <= !(((cyc - phase_start) >= 3) && ((cyc - phase_start) <= 8));
      default: out_ready <= 1'b0;
    endcase
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic sub);
    exp_t e;
    bit   done = 0;
    operA    = a;
    operB    = b;
    Cin      = cin;
    Sub      = sub;
    in_valid = 1'b1;
    for (int t = 0; t < 2000 && !done; t++) begin
      #3;
      if (in_ready) begin
        e     = model(a, b, cin, sub);
        e.cyc = cyc;
        sb.push_back(e);
        n_in++;
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 2000 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    operA    = $urandom;
    operB    = $urandom;
    Cin      = 1'($urandom);
    Sub      = 1'($urandom);
    repeat (n) @(negedge clk);
  endtask

  exp_t         mon_e;
  bit           hold_v = 0;
  logic [N-1:0] held_res;
  logic         held_c;
  logic         held_o;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v && out_valid) begin
        check("hold_result", resultOUT, held_res);
        check("hold_cout", Cout, held_c);
        check("hold_ovf", Ovf, held_o);
      end
      if (in_valid && !in_ready) begin
        check("full_occupancy", n_in - n_out - n_drop, STAGES);
        full_seen = 1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", resultOUT);
        end else begin
          mon_e = sb.pop_front();
          check("result", resultOUT, mon_e.res);
          check("cout", Cout, mon_e.cout);
          check("ovf", Ovf, mon_e.ovf);
          if (lat_chk) check("latency", cyc - mon_e.cyc, STAGES);
        end
        n_out++;
      end
      hold_v   = out_valid && !out_ready;
      held_res = resultOUT;
      held_c   = Cout;
      held_o   = Ovf;
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    operA    = '0;
    operB    = '0;
    Cin      = 1'b0;
    Sub      = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", resultOUT, 0);
    check("reset_cout", Cout, 0);
    check("reset_ovf", Ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    check("in_ready_after_reset", in_ready, 1);
    @(negedge clk);

    // Isolated directed vectors with exact latency, then a back-to-back burst.
    lat_chk = 1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); idle(STAGES + 2);
    send(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0); idle(STAGES + 2);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1); idle(STAGES + 2);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1); idle(STAGES + 2);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0); idle(STAGES + 2);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0); idle(STAGES + 2);
    send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1); idle(STAGES + 2);
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    idle(STAGES + 2);
    lat_chk = 0;

    // Scripted stall window on the output while six adds stream in.
    full_seen   = 0;
    phase_start = cyc;
    or_mode     = 2;
    for (int i = 1; i <= 6; i++) send(N'(i), N'(i), 1'b0, 1'b0);
    idle(16);
    check("bp_full_seen", full_seen, 1);
    check("bp_drained", sb.size(), 0);
    or_mode = 0;
    idle(2);

    // Reset with three transactions stuck in flight.
    or_mode = 3;
    idle(1);
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
    idle(2);
    #3;
    check("pre_reset_out_valid", out_valid, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_result", resultOUT, 0);
    check("async_reset_cout", Cout, 0);
    n_drop += sb.size();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    check("in_ready_after_midreset", in_ready, 1);
    @(negedge clk);
    or_mode = 0;
    idle(8);
    #3;
    check("no_stale_output", out_valid, 0);
    @(negedge clk);

    // Random traffic with random producer gaps and consumer stalls.
    or_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
    end
    or_mode = 0;
    for (int t = 0; t < 200 && sb.size() != 0; t++) idle(1);
    idle(STAGES + 2);
    check("final_sb_empty", sb.size(), 0);
    check("count_in_eq_out", n_in - n_drop, n_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
